// File: rtl/gpio_dbg_pkg.sv
// Shared types and constants for the GPIO debug-output block.
// Holds channel mode enum, config word field layout, counter width.
package gpio_dbg_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_LEVEL  = 2'd1,
        MODE_TOGGLE = 2'd2,
        MODE_PULSE  = 2'd3
    } mode_e;

    localparam int ADDR_W   = 4;
    localparam int WDATA_W  = 16;

    localparam int MODE_LSB = 0;
    localparam int MODE_W   = 2;
    localparam int SEL_LSB  = 4;
    localparam int SEL_W    = 4;
    localparam int LEN_LSB  = 8;
    localparam int LEN_W    = 8;

    localparam int CNT_W    = 16;
    localparam int MAX_CH   = 16;

endpackage

// File: rtl/gpio_dbg_out_if.sv
// Config-write and event-count-read bus of gpio_dbg_out.
// master: cfg_we/cfg_addr/cfg_wdata/cnt_raddr out, cnt_rdata in.
interface gpio_dbg_out_if;
    import gpio_dbg_pkg::*;

    logic               cfg_we;
    logic [ADDR_W-1:0]  cfg_addr;
    logic [WDATA_W-1:0] cfg_wdata;
    logic [ADDR_W-1:0]  cnt_raddr;
    logic [CNT_W-1:0]   cnt_rdata;

    modport master (
        output cfg_we,
        output cfg_addr,
        output cfg_wdata,
        output cnt_raddr,
        input  cnt_rdata
    );

    modport slave (
        input  cfg_we,
        input  cfg_addr,
        input  cfg_wdata,
        input  cnt_raddr,
        output cnt_rdata
    );

endinterface

// File: rtl/gpio_dbg_ch.sv
// One debug channel: source select, edge detect, mode, pulse, count.
// Ports: i_clk, i_reset, i_src, i_cfg_we, i_cfg_wdata, o_out, o_cnt.
module gpio_dbg_ch
    import gpio_dbg_pkg::*;
#(
    parameter int NUM_SRC = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NUM_SRC-1:0] i_src,
    input  logic               i_cfg_we,
    input  logic [WDATA_W-1:0] i_cfg_wdata,
    output logic               o_out,
    output logic [CNT_W-1:0]   o_cnt
);

    localparam logic [SEL_W:0] NSRC = (SEL_W + 1)'(NUM_SRC);

    mode_e              r_mode;
    logic [SEL_W-1:0]   r_sel;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_pcnt;
    logic               r_src_q;
    logic               r_edge;
    logic               r_out;
    logic [CNT_W-1:0]   r_cnt;

    logic [MAX_CH-1:0]  w_src_pad;
    logic               w_src;
    logic               w_edge;
    logic [LEN_W-1:0]   w_len_eff;
    logic               w_out_nxt;
    logic [LEN_W-1:0]   w_pcnt_nxt;
    logic               w_unused_bits;

    assign w_unused_bits = &{1'b0, i_cfg_wdata[3:2]};

    // Out-of-range selects read as a constant 0 source.
    assign w_src_pad = MAX_CH'(i_src);
    assign w_src     = ({1'b0, r_sel} < NSRC) ? w_src_pad[r_sel] : 1'b0;
    assign w_edge    = w_src & ~r_src_q;
    assign w_len_eff = (r_len == '0) ? LEN_W'(1) : r_len;

    // r_edge delays the edge one cycle so every mode lands at N+2.
    always_comb begin
        w_out_nxt  = r_out;
        w_pcnt_nxt = r_pcnt;
        unique case (r_mode)
            MODE_OFF:    w_out_nxt = 1'b0;
            MODE_LEVEL:  w_out_nxt = r_src_q;
            MODE_TOGGLE: if (r_edge) w_out_nxt = ~r_out;
            MODE_PULSE: begin
                if (r_edge) begin
                    w_out_nxt  = 1'b1;
                    w_pcnt_nxt = w_len_eff - LEN_W'(1);
                end else if (r_pcnt != '0) begin
                    w_pcnt_nxt = r_pcnt - LEN_W'(1);
                end else begin
                    w_out_nxt = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_mode  <= MODE_OFF;
            r_sel   <= '0;
            r_len   <= '0;
            r_pcnt  <= '0;
            r_src_q <= 1'b0;
            r_edge  <= 1'b0;
            r_out   <= 1'b0;
            r_cnt   <= '0;
        end else if (i_cfg_we) begin
            // A write drops any edge seen this cycle.
            r_mode  <= mode_e'(i_cfg_wdata[MODE_LSB +: MODE_W]);
            r_sel   <= i_cfg_wdata[SEL_LSB +: SEL_W];
            r_len   <= i_cfg_wdata[LEN_LSB +: LEN_W];
            r_pcnt  <= '0;
            r_src_q <= 1'b0;
            r_edge  <= 1'b0;
            r_out   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_src_q <= w_src;
            r_edge  <= w_edge;
            r_out   <= w_out_nxt;
            r_pcnt  <= w_pcnt_nxt;
            r_cnt   <= r_cnt + CNT_W'(w_edge);
        end
    end

    assign o_out = r_out;
    assign o_cnt = r_cnt;

endmodule

// File: rtl/gpio_dbg_out.sv
// Debug GPIO block: NUM_CH channels mapping events onto outputs.
// Ports: i_clk, i_reset, i_src[NUM_SRC], bus (slave), o_gpio[NUM_CH].
module gpio_dbg_out
    import gpio_dbg_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int NUM_SRC = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NUM_SRC-1:0] i_src,
    gpio_dbg_out_if.slave      bus,
    output logic [NUM_CH-1:0]  o_gpio
);

    // Padded to the full address space so unused slots read 0.
    logic [CNT_W-1:0] w_cnt [MAX_CH];
    logic [CNT_W-1:0] r_rdata;

    for (genvar g = 0; g < MAX_CH; g++) begin : g_ch
        if (g < NUM_CH) begin : g_on
            logic w_we;
            assign w_we = bus.cfg_we &&
                          (bus.cfg_addr == ADDR_W'(g));
            gpio_dbg_ch #(
                .NUM_SRC (NUM_SRC)
            ) u_ch (
                .i_clk       (i_clk),
                .i_reset     (i_reset),
                .i_src       (i_src),
                .i_cfg_we    (w_we),
                .i_cfg_wdata (bus.cfg_wdata),
                .o_out       (o_gpio[g]),
                .o_cnt       (w_cnt[g])
            );
        end else begin : g_off
            assign w_cnt[g] = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_cnt[bus.cnt_raddr];
        end
    end

    assign bus.cnt_rdata = r_rdata;

endmodule

// File: tb/tb_gpio_dbg_out.sv
// Scoreboard bench for gpio_dbg_out against an event-history model.
// Ports exercised: clock, reset, sources, config bus, count read.
`timescale 1ns/1ps
module tb_gpio_dbg_out;
    localparam int NUM_CH  = 4;
    localparam int NUM_SRC = 8;

    typedef struct {
        int               cyc;
        logic [NUM_CH-1:0] gpio;
        logic [15:0]      rd;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_SRC-1:0] src;
    logic [NUM_CH-1:0]  gpio;

    gpio_dbg_out_if bus ();

    gpio_dbg_out #(
        .NUM_CH  (NUM_CH),
        .NUM_SRC (NUM_SRC)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_src   (src),
        .bus     (bus),
        .o_gpio  (gpio)
    );

    initial forever #5 clk = ~clk;

    int cyc_n = 0;
    initial forever begin
        @(posedge clk);
        cyc_n++;
    end

    // stimulus for the current cycle
    logic [NUM_SRC-1:0] d_src   = '0;
    logic               d_we    = 1'b0;
    logic [3:0]         d_addr  = '0;
    logic [15:0]        d_wdata = '0;
    logic [3:0]         d_raddr = '0;
    logic               d_rst   = 1'b1;

    // model: per-channel epoch (cycle of last write) and config
    int m_w    [NUM_CH];
    int m_mode [NUM_CH];
    int m_sel  [NUM_CH];
    int m_len  [NUM_CH];
    int m_cum  [NUM_CH];
    int m_last [NUM_CH];
    // short per-cycle history, indexed by cycle mod 4
    bit [NUM_SRC-1:0] h_src [4];
    int h_cum  [NUM_CH][4];
    int h_last [NUM_CH][4];

    exp_t q[$];
    int n_chk  = 0;
    int n_fail = 0;

    initial begin
        for (int k = 0; k < 4; k++) h_src[k] = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_w[ch] = -10; m_mode[ch] = 0; m_sel[ch] = 0;
            m_len[ch] = 0; m_cum[ch] = 0; m_last[ch] = -1000;
            for (int k = 0; k < 4; k++) begin
                h_cum[ch][k] = 0; h_last[ch][k] = -1000;
            end
        end
    end

    function automatic logic [15:0] cfgw(int mode, int sel, int len);
        logic [15:0] v;
        v = '0;
        v[1:0]  = 2'(mode);
        v[7:4]  = 4'(sel);
        v[15:8] = 8'(len);
        return v;
    endfunction

    task automatic model_step(input int c);
        exp_t e;
        int   pi, t, w, last, len_eff;
        bit   wr, s, pv, ed;
        e.cyc = c + 1;
        // count register during cycle c = edges of the epoch so far
        if (d_rst) e.rd = '0;
        else if (d_raddr < 4'(NUM_CH)) e.rd = 16'(m_cum[d_raddr]);
        else e.rd = '0;
        pi = (c - 1) % 4;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            wr = d_rst || (d_we && (int'(d_addr) == ch));
            s = 1'b0;
            pv = 1'b0;
            if (m_sel[ch] < NUM_SRC) begin
                s = d_src[m_sel[ch]];
                if (c - 1 >= m_w[ch] + 1) pv = h_src[pi][m_sel[ch]];
            end
            ed = s && !pv && !wr;
            if (ed) begin
                m_cum[ch]++;
                m_last[ch] = c;
            end
            h_cum[ch][c % 4]  = m_cum[ch];
            h_last[ch][c % 4] = m_last[ch];
            if (wr) begin
                m_w[ch]    = c;
                m_mode[ch] = d_rst ? 0 : int'(d_wdata[1:0]);
                m_sel[ch]  = d_rst ? 0 : int'(d_wdata[7:4]);
                m_len[ch]  = d_rst ? 0 : int'(d_wdata[15:8]);
                m_cum[ch]  = 0;
                m_last[ch] = -1000;
            end
        end
        h_src[c % 4] = d_src;
        t = c + 1;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            w = m_w[ch];
            e.gpio[ch] = 1'b0;
            if (w < t - 2) begin
                case (m_mode[ch])
                    1: if (m_sel[ch] < NUM_SRC)
                           e.gpio[ch] = h_src[pi][m_sel[ch]];
                    2: e.gpio[ch] = h_cum[ch][pi][0];
                    3: begin
                        len_eff = (m_len[ch] == 0) ? 1 : m_len[ch];
                        last = h_last[ch][pi];
                        e.gpio[ch] = (last >= w + 1) &&
                                     (t < last + 2 + len_eff);
                    end
                    default: e.gpio[ch] = 1'b0;
                endcase
            end
        end
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        src           = d_src;
        rst           = d_rst;
        bus.cfg_we    = d_we;
        bus.cfg_addr  = d_addr;
        bus.cfg_wdata = d_wdata;
        bus.cnt_raddr = d_raddr;
        model_step(cyc_n);
    endtask

    task automatic idle(input int n);
        d_we = 1'b0;
        repeat (n) tick();
    endtask

    task automatic wr(input int addr, input logic [15:0] data);
        d_we = 1'b1;
        d_addr = 4'(addr);
        d_wdata = data;
        tick();
        d_we = 1'b0;
    endtask

    // monitor: compare whatever the DUT shows against the queue head
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (q.size() > 0 && q[0].cyc == cyc_n) begin
            e = q.pop_front();
            n_chk++;
            if (gpio !== e.gpio) begin
                n_fail++;
                $display("FAIL gpio cyc=%0d got=%b exp=%b",
                         cyc_n, gpio, e.gpio);
            end
            n_chk++;
            if (bus.cnt_rdata !== e.rd) begin
                n_fail++;
                $display("FAIL cnt_rdata cyc=%0d got=%h exp=%h",
                         cyc_n, bus.cnt_rdata, e.rd);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc_n);
        $fatal(1, "watchdog");
    end

    initial begin
        src = '0; rst = 1'b1;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0;
        bus.cfg_wdata = '0; bus.cnt_raddr = '0;
        d_rst = 1'b1;
        tick(); tick();
        d_rst = 1'b0;
        idle(3);

        // toggle on src 2, three edges
        wr(0, cfgw(2, 2, 0));
        d_raddr = 4'd0;
        for (int i = 0; i < 3; i++) begin
            d_src = 8'h04; tick();
            d_src = 8'h00; tick(); tick(); tick();
        end
        idle(3);

        // pulse len 5, then restart inside the pulse
        d_raddr = 4'd1;
        wr(1, cfgw(3, 3, 5));
        idle(2);
        d_src = 8'h08; tick();
        d_src = 8'h00; idle(10);
        d_src = 8'h08; tick();
        d_src = 8'h00; tick(); tick();
        d_src = 8'h08; tick();
        d_src = 8'h00; idle(12);

        // pulse len 0 behaves as length 1
        wr(1, cfgw(3, 3, 0));
        idle(2);
        for (int i = 0; i < 3; i++) begin
            d_src = 8'h08; tick();
            d_src = 8'h00; tick(); tick();
        end

        // write and edge in the same cycle on ch3
        d_raddr = 4'd3;
        wr(3, cfgw(2, 5, 0));
        idle(2);
        d_we = 1'b1; d_addr = 4'd3; d_wdata = cfgw(2, 5, 0);
        d_src = 8'h20; tick();
        d_we = 1'b0; d_src = 8'h00;
        idle(5);

        // write to a channel that does not exist
        wr(15, cfgw(1, 0, 0));
        d_src = 8'hFF; tick();
        d_src = 8'h00; idle(4);

        // random traffic, including bad selects and resets
        for (int i = 0; i < 3000; i++) begin
            d_src   = NUM_SRC'($urandom);
            d_we    = ($urandom_range(0, 9) == 0);
            d_addr  = 4'($urandom_range(0, 15));
            d_wdata = 16'($urandom);
            d_raddr = 4'($urandom_range(0, 15));
            d_rst   = ($urandom_range(0, 299) == 0);
            tick();
        end
        d_rst = 1'b0; d_we = 1'b0; d_src = '0;
        idle(3);

        // reset while toggle is high and a pulse is running
        wr(0, cfgw(2, 1, 0));
        wr(1, cfgw(3, 1, 100));
        idle(2);
        d_src = 8'h02; tick();
        d_src = 8'h00; idle(4);
        d_rst = 1'b1; tick();
        d_rst = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            d_raddr = 4'(i); tick();
        end

        // counter wrap on ch2
        wr(2, cfgw(1, 0, 0));
        d_raddr = 4'd2;
        for (int i = 0; i < 65537; i++) begin
            d_src = 8'h01; tick();
            d_src = 8'h00; tick();
        end
        idle(3);

        @(posedge clk);
        @(posedge clk);
        #1;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain left=%0d exp=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
